// File: rtl/tournament_chooser_gen.sv
// Tournament chooser table: saturating counters pick the local or global predictor.
// Define TOURN_STATS_EN to add the sel_global_cnt / sel_local_cnt selection counters.
module tournament_chooser_gen #(
   parameter int unsigned HIST_WIDTH  = 10,
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned CTR_WIDTH   = 2,
   parameter int unsigned PC_LSB      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           read_pc,
   input  logic                  read_valid,
   output logic                  prediction,
   output logic                  pred_valid,
   output logic                  ready,
   input  logic                  write,
   input  logic [15:0]           write_pc,
   input  logic                  taken,
   input  logic                  local_correct,
   input  logic                  global_correct,
   output logic [HIST_WIDTH-1:0] history
`ifdef TOURN_STATS_EN
   ,
   output logic [15:0]           sel_global_cnt,
   output logic [15:0]           sel_local_cnt
`endif
);

   localparam int unsigned DEPTH = 2 ** INDEX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] WEAK_LOCAL = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
   localparam logic [INDEX_WIDTH-1:0] PTR_LAST = '1;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [HIST_WIDTH-1:0]  hist_q, hist_d;
   logic                   pred_q, pred_d;
   logic                   pv_q, pv_d;
   logic [CTR_WIDTH-1:0]   table_q [DEPTH];

   logic                   run;
   logic [INDEX_WIDTH-1:0] hx, ridx, widx;
   logic [CTR_WIDTH-1:0]   cur_ctr, upd_ctr, rd_ctr;
   logic                   upd_chg, upd_en;
   logic                   we;
   logic [INDEX_WIDTH-1:0] waddr;
   logic [CTR_WIDTH-1:0]   wdata;
   logic                   unused_pc;

   assign run  = (state_q == StRun);
   assign hx   = INDEX_WIDTH'(hist_q);
   assign ridx = hx ^ read_pc[PC_LSB +: INDEX_WIDTH];
   assign widx = hx ^ write_pc[PC_LSB +: INDEX_WIDTH];
   assign unused_pc = ^{read_pc, write_pc};

   assign cur_ctr = table_q[widx];
   assign upd_en  = run && write;

   always_comb begin
      upd_ctr = cur_ctr;
      upd_chg = 1'b0;
      if (global_correct && !local_correct && cur_ctr != CTR_MAX) begin
         upd_ctr = cur_ctr + CTR_WIDTH'(1);
         upd_chg = 1'b1;
      end else if (local_correct && !global_correct && cur_ctr != '0) begin
         upd_ctr = cur_ctr - CTR_WIDTH'(1);
         upd_chg = 1'b1;
      end
   end

   // Single write port shared by the init sweep and resolved-branch updates.
   always_comb begin
      we    = 1'b0;
      waddr = widx;
      wdata = upd_ctr;
      if (!run) begin
         we    = 1'b1;
         waddr = ptr_q;
         wdata = WEAK_LOCAL;
      end else if (upd_en && upd_chg) begin
         we = 1'b1;
      end
   end

   // Write-first: a same-cycle update to the looked-up entry is forwarded.
   assign rd_ctr = (upd_en && (widx == ridx)) ? upd_ctr : table_q[ridx];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hist_d  = hist_q;
      pred_d  = pred_q;
      pv_d    = 1'b0;
      unique case (state_q)
         StInit: begin
            ptr_d = ptr_q + INDEX_WIDTH'(1);
            if (ptr_q == PTR_LAST) state_d = StRun;
         end
         StRun: begin
            if (write) hist_d = HIST_WIDTH'({hist_q, taken});
            if (read_valid) begin
               pv_d   = 1'b1;
               pred_d = rd_ctr[CTR_WIDTH-1];
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StInit;
         ptr_q   <= '0;
         hist_q  <= '0;
         pred_q  <= 1'b0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hist_q  <= hist_d;
         pred_q  <= pred_d;
         pv_q    <= pv_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) table_q[waddr] <= wdata;
   end

   assign prediction = pred_q;
   assign pred_valid = pv_q;
   assign ready      = run;
   assign history    = hist_q;

`ifdef TOURN_STATS_EN
   logic [15:0] glob_cnt_q, loc_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         glob_cnt_q <= '0;
         loc_cnt_q  <= '0;
      end else if (pv_q) begin
         if (pred_q && glob_cnt_q != 16'hFFFF) glob_cnt_q <= glob_cnt_q + 16'd1;
         if (!pred_q && loc_cnt_q != 16'hFFFF) loc_cnt_q <= loc_cnt_q + 16'd1;
      end
   end

   assign sel_global_cnt = glob_cnt_q;
   assign sel_local_cnt  = loc_cnt_q;
`endif

endmodule

// File: tb/tb_tournament_chooser_gen.sv
// Self-checking bench for tournament_chooser_gen: directed steps plus random traffic
// compared against an arithmetic model of the chooser table.
module tb_tournament_chooser_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] read_pc;
   logic        read_valid;
   logic        prediction;
   logic        pred_valid;
   logic        ready;
   logic        write;
   logic [15:0] write_pc;
   logic        taken;
   logic        local_correct;
   logic        global_correct;
   logic [9:0]  history;
`ifdef TOURN_STATS_EN
   logic [15:0] sel_global_cnt;
   logic [15:0] sel_local_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: counter values 0..3 per entry, history as an integer.
   int ctr [1024];
   int m_hist;
   bit m_pred, m_pv, m_run;

   always #5 clk = ~clk;

   tournament_chooser_gen dut (
      .clk           (clk),
      .reset         (reset),
      .read_pc       (read_pc),
      .read_valid    (read_valid),
      .prediction    (prediction),
      .pred_valid    (pred_valid),
      .ready         (ready),
      .write         (write),
      .write_pc      (write_pc),
      .taken         (taken),
      .local_correct (local_correct),
      .global_correct(global_correct),
      .history       (history)
`ifdef TOURN_STATS_EN
      ,
      .sel_global_cnt(sel_global_cnt),
      .sel_local_cnt (sel_local_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      read_valid     = 1'b0;
      read_pc        = '0;
      write          = 1'b0;
      write_pc       = '0;
      taken          = 1'b0;
      local_correct  = 1'b0;
      global_correct = 1'b0;
   endtask

   task automatic model_edge();
      int ridx, widx, c;
      if (!m_run) begin
         m_pv = 1'b0;
         return;
      end
      ridx = (m_hist ^ int'(read_pc >> 1)) % 1024;
      widx = (m_hist ^ int'(write_pc >> 1)) % 1024;
      if (write) begin
         c = ctr[widx];
         if (global_correct && !local_correct) c = (c < 3) ? c + 1 : 3;
         else if (local_correct && !global_correct) c = (c > 0) ? c - 1 : 0;
         ctr[widx] = c;
         m_hist = (m_hist * 2 + int'(taken)) % 1024;
      end
      if (read_valid) begin
         m_pred = (ctr[ridx] >= 2);
         m_pv   = 1'b1;
      end else begin
         m_pv = 1'b0;
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      check({tag, "_pv"}, pred_valid, m_pv);
      check({tag, "_pred"}, prediction, m_pred);
      check({tag, "_hist"}, history, m_hist);
      check({tag, "_ready"}, ready, m_run);
   endtask

   task automatic reset_and_init();
      int cycles;
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_pv", pred_valid, 0);
      check("rst_pred", prediction, 0);
      check("rst_hist", history, 0);
`ifdef TOURN_STATS_EN
      check("rst_glob_cnt", sel_global_cnt, 0);
      check("rst_loc_cnt", sel_local_cnt, 0);
`endif
      @(negedge clk);
      reset  = 1'b0;
      cycles = 0;
      // Lookups and updates offered during the sweep must be ignored.
      do begin
         read_valid     = 1'($urandom);
         read_pc        = 16'($urandom);
         write          = 1'($urandom);
         write_pc       = 16'($urandom);
         taken          = 1'b1;
         global_correct = 1'($urandom);
         local_correct  = 1'($urandom);
         @(posedge clk);
         #1;
         cycles++;
         check("init_pv", pred_valid, 0);
         check("init_hist", history, 0);
      end while (!ready && cycles < 2000);
      check("init_cycles", cycles, 1024);
      idle();
      for (int i = 0; i < 1024; i++) ctr[i] = 1;
      m_hist = 0;
      m_pred = 1'b0;
      m_pv   = 1'b0;
      m_run  = 1'b1;
   endtask

   initial begin
      m_run = 1'b0;
      reset = 1'b1;
      idle();
      reset_and_init();

      // First lookup after init sees a weak-local counter.
      read_valid = 1'b1;
      read_pc    = 16'($urandom);
      step("rd_init");
      check("rd_init_const", prediction, 0);
      idle();

      // Drive entry 1 up to saturation.
      write          = 1'b1;
      write_pc       = 16'h0002;
      global_correct = 1'b1;
      repeat (3) step("inc");
      idle();
      read_valid = 1'b1;
      read_pc    = 16'h0002;
      step("rd_hi");
      check("sat_hi_const", prediction, 1);
      idle();

      // Drive entry 1 down past zero, then neutral updates.
      write         = 1'b1;
      write_pc      = 16'h0002;
      local_correct = 1'b1;
      repeat (4) step("dec");
      global_correct = 1'b1;
      step("both_ok");
      global_correct = 1'b0;
      local_correct  = 1'b0;
      step("both_bad");
      idle();
      read_valid = 1'b1;
      read_pc    = 16'h0002;
      step("rd_lo");
      check("sat_lo_const", prediction, 0);
      idle();

      // History fill with taken branches.
      write    = 1'b1;
      write_pc = 16'h0100;
      taken    = 1'b1;
      repeat (4) step("hist_fill");
      check("hist_f_const", history, 10'h00F);
      idle();
      read_valid = 1'b1;
      read_pc    = 16'h0000;
      step("rd_f");
      check("rd_f_const", prediction, 0);
      idle();

      // Same-cycle update and lookup of entry 0xF (counter 01).
      write          = 1'b1;
      write_pc       = 16'h0000;
      read_valid     = 1'b1;
      read_pc        = 16'h0000;
      global_correct = 1'b1;
      step("bypass");
      check("bypass_const", prediction, 1);
      idle();

      // Random traffic; small PCs half the time to force index collisions.
      repeat (3000) begin
         read_valid     = 1'($urandom);
         write          = 1'($urandom);
         taken          = 1'($urandom);
         global_correct = 1'($urandom);
         local_correct  = 1'($urandom);
         read_pc        = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         write_pc       = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         step("rand");
      end
      idle();

      // Reset partway through a sweep restarts it from entry 0.
      m_run = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      check("mid_sweep_ready", ready, 0);
      reset_and_init();

      // Three global-selected lookups.
      write          = 1'b1;
      write_pc       = 16'h0002;
      global_correct = 1'b1;
      repeat (2) step("stat_inc");
      idle();
      read_valid = 1'b1;
      read_pc    = 16'h0002;
      repeat (3) step("stat_rd");
      idle();
      step("stat_idle");
      check("stat_rd_const", prediction, 1);
`ifdef TOURN_STATS_EN
      check("sel_global_cnt", sel_global_cnt, 3);
      check("sel_local_cnt", sel_local_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tournament_chooser_gen.md
Name: tournament_chooser_gen

Overview:
- Parametrised tournament chooser table: per-entry saturating counters select between local and global direction predictors.
- Sits in the fetch stage beside the local and global BHTs; the fetch mux consumes `prediction`.
- Indexed by global history XOR PC, with a registered one-cycle read.
- Adds over the previous chooser: arbitrary counter/history/index widths, a reset sweep FSM that initialises the table, write-first bypass, and explicit per-predictor correctness inputs.

Parameters:
- HIST_WIDTH, 10, global history length; must be <= INDEX_WIDTH.
- INDEX_WIDTH, 10, log2 of table depth (2^INDEX_WIDTH entries).
- CTR_WIDTH, 2, chooser counter width; must be >= 1.
- PC_LSB, 1, lowest PC bit used in the index.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- read_pc, input, 16, fetch PC (lc3b_word).
- read_valid, input, 1, lookup request this cycle.
- prediction, output, 1, registered select: 1 = use global predictor, 0 = use local predictor.
- pred_valid, output, 1, prediction is valid for the lookup of the previous cycle.
- ready, output, 1, table initialised; lookups and updates are accepted.
- write, input, 1, resolved-branch update strobe.
- write_pc, input, 16, PC of the resolving branch.
- taken, input, 1, resolved direction; shifted into history.
- local_correct, input, 1, local predictor was right for this branch.
- global_correct, input, 1, global predictor was right for this branch.
- history, output, HIST_WIDTH, current global history register.

Behaviour:
- Reset (async, any state) forces:
  - FSM to INIT and sweep pointer to 0.
  - history, prediction, pred_valid and ready to 0.
  - A reset in the middle of a sweep or a RUN restarts the sweep from entry 0.
- FSM INIT:
  - Each cycle, write entry[ptr] = WEAK_LOCAL, where WEAK_LOCAL = 2^(CTR_WIDTH-1)-1 (2'b01 at default; 0 when CTR_WIDTH = 1). Then ptr increments.
  - On the cycle ptr = 2^INDEX_WIDTH-1 is written, go to RUN.
  - INIT takes exactly 2^INDEX_WIDTH cycles after reset deassertion.
  - ready = 0 throughout INIT.
  - write and read_valid are ignored during INIT: history does not shift and pred_valid stays 0.
- FSM RUN:
  - ready = 1.
  - RUN has no exit except reset.
- Index formation:
  - hx = history zero-extended on the MSB side to INDEX_WIDTH.
  - ridx = hx XOR read_pc[PC_LSB+INDEX_WIDTH-1:PC_LSB].
  - widx = hx XOR write_pc[same bits].
  - Both indices use the history value before this cycle's shift.
- Read path, 1-cycle latency:
  - On a clock edge with RUN and read_valid: prediction <= MSB of entry[ridx]; pred_valid <= 1.
  - Otherwise pred_valid <= 0 and prediction holds its value.
- Update path (RUN and write):
  - history <= {history[HIST_WIDTH-2:0], taken}. When HIST_WIDTH = 1, history <= taken.
  - If global_correct and not local_correct: entry[widx] increments, saturating at 2^CTR_WIDTH-1.
  - If local_correct and not global_correct: entry[widx] decrements, saturating at 0.
  - If both are correct or both are wrong: entry unchanged; no array write is required.
- Simultaneous read and update to the same index (ridx = widx):
  - Write-first: prediction takes the MSB of the post-update counter.
  - The history used for ridx is still the pre-shift value.
- Storage:
  - Single write port: only one write per cycle, either an INIT sweep or an update.
  - Read port: any read style is allowed as long as the 1-cycle output timing holds.

Optional Feature:
- Macro: TOURN_STATS_EN.
- Defined: adds outputs sel_global_cnt [15:0] and sel_local_cnt [15:0].
  - On each cycle pred_valid goes high, the counter matching the registered prediction increments.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold reset low with defaults → ready rises exactly 1024 cycles after deassertion. read_valid=1 with any PC → pred_valid=1 and prediction=0 one cycle later; history=0.
- Updates in RUN with write_pc=16'h0002, history=0, global_correct=1, local_correct=0, taken=0 each time:
  - Two updates → entry 1 counts 01 → 10 → 11.
  - A further update holds at 11; a read of 16'h0002 returns prediction=1.
  - Each update shifts in taken=0, so history stays 0 and the index stays at entry 1.
- Same entry, four updates with local_correct=1, global_correct=0 → counter 11→10→01→00→00 (saturates at 0). Both-correct and both-wrong updates leave it unchanged.
- Four writes with taken=1 → history=10'h00F. A read of 16'h0000 then addresses entry 10'h00F.
- Same-cycle write and read to one index, counter 01, global_correct=1 → prediction=1 on the next cycle (write-first bypass).
- Assert reset midway through the INIT sweep (cycle 500) → sweep restarts and ready rises 1024 cycles after the second deassertion. With TOURN_STATS_EN, 3 global-selected lookups → sel_global_cnt=3 and sel_local_cnt=0.
